// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
//   state_e    : control FSM states
//   NIBBLE_W   : width of the single adder slice
//   idx_width  : nibble index register width, clog2(nib) with a floor of 1
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-nibble datapath still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
//   master : operand producer / result consumer side
//   slave  : the adder itself
//   in_valid/in_ready/a/b/sub       operand handshake, sub=1 selects a-b
//   out_valid/out_ready/sum/cout/ovf result handshake
//   busy                            adder is not idle
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/nibble_serial_adder_slice.sv
// Combinational 4-bit adder slice with carry in/out.
//   a_i, b_i : nibble operands
//   cin_i    : carry in
//   s_o      : nibble sum
//   cout_o   : carry out
module nibble_add_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                cout_o
);

  assign {cout_o, s_o} = (NIBBLE_W+1)'(a_i) + (NIBBLE_W+1)'(b_i)
                       + (NIBBLE_W+1)'(cin_i);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract unit that resolves one nibble per clock through a
// single 4-bit slice, carrying between nibbles in a register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand/result handshake (slave modport)
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = idx_width(NIB);
  localparam int unsigned MSB   = WIDTH - 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_c;

  assign nib_a = op_a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b = op_b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  nibble_add_slice u_slice (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (carry_q),
    .s_o    (nib_s),
    .cout_o (nib_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Subtract as a + ~b + 1: the +1 enters as the initial carry.
          op_a_d  = bus.a;
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_s;
        carry_d = nib_c;
        if (idx_q == IDX_W'(NIB - 1)) begin
          // Publish only the complete result so partial nibbles never leak.
          sum_d   = work_d;
          cout_d  = nib_c;
          ovf_d   = (op_a_q[MSB] == op_b_q[MSB]) &&
                    (nib_s[NIBBLE_W-1] != op_a_q[MSB]);
          state_d = ST_DONE;
        end else begin
          idx_d = IDX_W'(idx_q + 1'b1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are decodes of the state register; in_ready is held low in reset.
  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16) with a result scoreboard.
module tb_nibble_serial_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nibble_serial_adder_if #(.WIDTH(16)) bus ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  // Reference built from integer arithmetic, independent of the nibble datapath.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    int ua, ub, sa, sbv, ures, sres;
    exp_t e;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (s) begin
      ures   = ua - ub;
      sres   = sa - sbv;
      e.cout = (ua >= ub);
    end else begin
      ures   = ua + ub;
      sres   = sa + sbv;
      e.cout = (ures > 65535);
    end
    e.sum = 16'(ures);
    e.ovf = (sres > 32767) || (sres < -32768);
    return e;
  endfunction

  // Scoreboard consumer: compare on every result handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("sum",  32'(bus.sum),  32'(e.sum));
        check_eq("cout", 32'(bus.cout), 32'(e.cout));
        check_eq("ovf",  32'(bus.ovf),  32'(e.ovf));
      end
    end
  end

  // Present one operation; optionally score it and measure accept-to-out_valid latency.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input exp_t e, input bit track, input bit wait_done);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check_eq("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    if (track) sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.out_valid && n < 20);
      check_eq("latency", 32'(n - 1), 32'd4);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t hold;
    exp_t nxt;
    bit   ov_seen;
    logic [15:0] ra, rb;
    logic        rs;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset: two rising edges with rst high.
    @(negedge clk);
    check_eq("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_sum",       32'(bus.sum),       32'd0);
    check_eq("rst_cout",      32'(bus.cout),      32'd0);
    check_eq("rst_ovf",       32'(bus.ovf),       32'd0);
    check_eq("rst_busy",      32'(bus.busy),      32'd0);

    // Directed arithmetic cases.
    send(16'h1234, 16'h0FCD, 1'b0, mk(16'h2201, 1'b0, 1'b0), 1'b1, 1'b1); drain();
    send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b1, 1'b1); drain();
    send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1'b1, 1'b1); drain();
    send(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 1'b1, 1'b1); drain();
    send(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), 1'b1, 1'b1); drain();

    // Backpressure: result held while new operands wait at the input.
    bus.out_ready = 1'b0;
    hold = mk(16'h8000, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, hold, 1'b1, 1'b1);
    nxt = mk(16'h0FFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = 16'h00F0;
    bus.b        = 16'h0F0F;
    bus.sub      = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check_eq("bp_sum",       32'(bus.sum),       32'(hold.sum));
      check_eq("bp_cout_ovf",  32'({bus.cout, bus.ovf}), 32'({hold.cout, hold.ovf}));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    sb.push_back(nxt);
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("bp_idle_busy",     32'(bus.busy),     32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_new_accepted", 32'(bus.busy), 32'd1);
    drain();

    // Reset while idx==2 of an add: operation must vanish.
    send(16'h1234, 16'h0FCD, 1'b0, mk(16'h0, 1'b0, 1'b0), 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy",      32'(bus.busy),      32'd0);
    check_eq("mid_rst_sum",       32'(bus.sum),       32'd0);
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    ov_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check_eq("mid_rst_no_result", 32'(ov_seen), 32'd0);
    send(16'h0001, 16'h0002, 1'b0, mk(16'h0003, 1'b0, 1'b0), 1'b1, 1'b1); drain();

    // Random operations against the integer model.
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(1, 0));
      send(ra, rb, rs, model(ra, rb, rs), 1'b1, 1'b1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit add/subtract unit that processes one 4-bit nibble per clock.
- Each cycle, one nibble pair and the registered carry go through a single 4-bit adder slice; the slice carry-out is registered and fed into the next nibble.
- Sits between an operand-producing datapath and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against a full-width carry-select adder.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and >= 4.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b and sub are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B; 1: A-B.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset effect: state goes to IDLE; sum, cout, ovf and out_valid go to 0; internal carry and nibble index go to 0. While rst is high, in_ready is forced to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture opA = a and opB = (sub ? ~b : b), set carry = sub, set idx = 0, go to RUN.
- RUN, one nibble per cycle:
  - {c, s} = opA[4*idx+:4] + opB[4*idx+:4] + carry.
  - Working nibble idx <= s; carry <= c.
  - If idx == NIB-1: load the sum output register from the working register, set cout = c, set ovf = (opA[MSB] == opB[MSB]) & (s[3] != opA[MSB]), go to DONE.
  - Otherwise idx <= idx+1.
  - in_ready = 0.
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable; in_ready = 0.
  - On out_ready: go to IDLE.
  - in_valid is ignored in this state; operands are not captured.
- Latency: out_valid first goes high exactly NIB cycles after the accepting edge (WIDTH=16 gives 4).
- Throughput: at most one operation per NIB+2 cycles. There is no overlap of accept and done.
- Output holding: sum, cout and ovf keep the last result after the handshake. They change only on the final RUN cycle or on reset.
- Intermediate nibbles are never visible on sum.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- out_valid is a registered state decode and is glitch-free.
- Reset mid-RUN or mid-DONE: the operation is discarded, the state goes to IDLE, and no out_valid pulse occurs.
- Back-to-back inputs: a held in_valid is accepted again only after the state returns to IDLE.
- WIDTH=4: a single RUN cycle, so latency is 1.

Decomposition:
- Shared package:
  - State enum (IDLE, RUN, DONE).
  - NIBBLE_W = 4 constant.
  - Index width function clog2(NIB), minimum 1.
- Sub-module nibble_add_slice: combinational, 4-bit a/b, cin; outputs 4-bit s and cout. It is instantiated once and is unit-testable alone.
- Control FSM, index counter and operand registers stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles, then release.
  -> out_valid=0, sum=0, cout=0, ovf=0, busy=0; in_ready=1 on the first cycle after release; in_ready=0 while rst is high.
- Add, WIDTH=16: 0x1234 + 0x0FCD, sub=0.
  -> sum=0x2201, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
- Carry ripple across nibbles and signed overflow:
  - 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0.
  - 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  -> out_valid stays 1, sum/cout/ovf are stable, in_ready=0, new operands are not taken.
  -> Raise out_ready: next cycle is IDLE with in_ready=1. The new operation is then accepted and produces its own correct result.
- Reset mid-operation: assert rst for 1 cycle when idx=2 of a 0x1234+0x0FCD add.
  -> Next cycle is IDLE, sum=0, out_valid never rises for that operation; a following 0x0001+0x0002 returns 0x0003.
